mac_rx_dispatch: RTL and testbench

//  Ethernet receive front end between the PHY byte stream and the protocol decoders (arp, ip).
//  - Strips the preamble/SFD and filters on destination MAC (local or broadcast).
//  - Captures the sender MAC and steers payload bytes to arp or ip by ethertype, using per-protocol

---
 rtl/mac_rx_dispatch.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mac_rx_dispatch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_dispatch.sv
// mac_rx_dispatch: Ethernet receive front end between the PHY byte stream and
// the ARP/IP decoders. It strips the preamble/SFD and filters on the destination
// MAC (local or broadcast). It captures the sender MAC and steers payload bytes
// to the ARP or IP enable according to the ethertype.
// Build option: define MAC_RX_FCS_CHECK_EN to add a CRC-32 check of the FCS.
// Without that macro, fcs_ok_o simply accompanies every frame_done_o pulse.

module mac_rx_dispatch #(
  parameter int unsigned PREAMBLE_MIN = 2,
  parameter int unsigned MAX_FRAME    = 1522
) (
  input  logic        rx_clock,
  input  logic        reset,
  input  logic        phy_rx_dv_i,
  input  logic [7:0]  phy_rx_data_i,
  input  logic [47:0] local_mac_i,
  output logic [7:0]  rx_data_o,
  output logic [47:0] remote_mac_o,
  output logic        arp_rx_enable_o,
  output logic        ip_rx_enable_o,
  output logic        is_broadcast_o,
  output logic        frame_done_o,
  output logic        fcs_ok_o,
  output logic        rx_error_o
);

  localparam logic [7:0]  PRE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE   = 8'hD5;
  localparam logic [47:0] BCAST_MAC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] TYPE_ARP   = 16'h0806;
  localparam logic [15:0] TYPE_IP    = 16'h0800;
  localparam logic [2:0]  PRE_MIN    = 3'(PREAMBLE_MIN);
  localparam logic [2:0]  PRE_SAT    = 3'd7;
  // Byte counter values (bytes already seen since the first DST byte) at which
  // the header fields complete.
  localparam logic [10:0] DST_LAST   = 11'd5;
  localparam logic [10:0] SRC_LAST   = 11'd11;
  localparam logic [10:0] TYPE_FIRST = 11'd12;
  localparam logic [10:0] TYPE_LAST  = 11'd13;
  localparam logic [10:0] CNT_LIMIT  = 11'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic        dv_prev_q, dv_prev_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] shadow_q, shadow_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic        sel_arp_q, sel_arp_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [47:0] remote_q, remote_d;
  logic        bcast_q, bcast_d;
  logic        arp_en_q, arp_en_d;
  logic        ip_en_q, ip_en_d;
  logic        end_pend_q, end_pend_d;
  logic        frame_done_q, frame_done_d;
  logic        fcs_ok_q, fcs_ok_d;
  logic        rx_error_q, rx_error_d;
  logic [47:0] dst_next;

  assign dst_next = {dst_q[39:0], phy_rx_data_i};

`ifdef MAC_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_POLY_REV = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

  logic [31:0] crc_q, crc_d;
  logic        match_q, match_d;
  logic        end_pend2_q, end_pend2_d;

  function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REV) : (c >> 1);
    end
    return c;
  endfunction
`endif

  // Frame FSM and header/payload datapath: next-state for everything the frame walks through
  always_comb begin
    state_d    = state_q;
    dv_prev_d  = phy_rx_dv_i;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    dst_d      = dst_q;
    shadow_d   = shadow_q;
    type_hi_d  = type_hi_q;
    sel_arp_d  = sel_arp_q;
    rx_data_d  = rx_data_q;
    remote_d   = remote_q;
    bcast_d    = bcast_q;
    arp_en_d   = 1'b0;
    ip_en_d    = 1'b0;
    end_pend_d = 1'b0;
    rx_error_d = 1'b0;

    if (phy_rx_dv_i) begin
      rx_data_d = phy_rx_data_i;
    end

    if (!phy_rx_dv_i) begin
      state_d    = S_IDLE;
      end_pend_d = (state_q == S_PAYLOAD) && (arp_en_q || ip_en_q);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!dv_prev_q && (phy_rx_data_i == PRE_BYTE)) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DISCARD;
          end
        end
        S_PREAMBLE: begin
          if (phy_rx_data_i == PRE_BYTE) begin
            if (pre_cnt_q != PRE_SAT) begin
              pre_cnt_d = pre_cnt_q + 3'd1;
            end
          end else if ((phy_rx_data_i == SFD_BYTE) && (pre_cnt_q >= PRE_MIN)) begin
            state_d    = S_DST;
            byte_cnt_d = '0;
          end else begin
            state_d = S_DISCARD;
          end
        end
        S_DST: begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          dst_d      = dst_next;
          if (byte_cnt_q == DST_LAST) begin
            if ((dst_next == local_mac_i) || (dst_next == BCAST_MAC)) begin
              state_d = S_SRC;
              bcast_d = (dst_next == BCAST_MAC);
            end else begin
              state_d = S_DISCARD;
            end
          end
        end
        S_SRC: begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          shadow_d   = {shadow_q[39:0], phy_rx_data_i};
          if (byte_cnt_q == SRC_LAST) begin
            state_d = S_TYPE;
          end
        end
        S_TYPE: begin
          byte_cnt_d = byte_cnt_q + 11'd1;
          if (byte_cnt_q == TYPE_FIRST) begin
            type_hi_d = phy_rx_data_i;
          end else if (byte_cnt_q == TYPE_LAST) begin
            if ({type_hi_q, phy_rx_data_i} == TYPE_ARP) begin
              state_d   = S_PAYLOAD;
              sel_arp_d = 1'b1;
              remote_d  = shadow_q;
            end else if ({type_hi_q, phy_rx_data_i} == TYPE_IP) begin
              state_d   = S_PAYLOAD;
              sel_arp_d = 1'b0;
              remote_d  = shadow_q;
            end else begin
              state_d = S_DISCARD;
            end
          end
        end
        S_PAYLOAD: begin
          if (byte_cnt_q == CNT_LIMIT) begin
            state_d    = S_DISCARD;
            rx_error_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 11'd1;
            arp_en_d   = sel_arp_q;
            ip_en_d    = !sel_arp_q;
          end
        end
        S_DISCARD: begin
          state_d = S_DISCARD;
        end
        default: begin
          state_d = S_DISCARD;
        end
      endcase
    end
  end

`ifdef MAC_RX_FCS_CHECK_EN
  // CRC over dst..FCS, compared once at end of frame; done/ok emerge one stage later
  always_comb begin
    crc_d        = crc_q;
    match_d      = match_q;
    end_pend2_d  = end_pend_q;
    frame_done_d = end_pend2_q;
    fcs_ok_d     = end_pend2_q && match_q;
    if (phy_rx_dv_i) begin
      if (state_q == S_PREAMBLE) begin
        crc_d = '1;
      end else if (state_q inside {S_DST, S_SRC, S_TYPE, S_PAYLOAD}) begin
        crc_d = crcByte(crc_q, phy_rx_data_i);
      end
    end
    if (end_pend_d) begin
      match_d = (crc_q == CRC_RESIDUE);
    end
  end
`else
  // Without FCS checking every completed frame is reported as good
  always_comb begin
    frame_done_d = end_pend_q;
    fcs_ok_d     = end_pend_q;
  end
`endif

  // State and output registers, synchronous active-high reset
  always_ff @(posedge rx_clock) begin
    if (reset) begin
      state_q      <= S_DISCARD;
      dv_prev_q    <= 1'b1;
      pre_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      dst_q        <= '0;
      shadow_q     <= '0;
      type_hi_q    <= '0;
      sel_arp_q    <= 1'b0;
      rx_data_q    <= '0;
      remote_q     <= '0;
      bcast_q      <= 1'b0;
      arp_en_q     <= 1'b0;
      ip_en_q      <= 1'b0;
      end_pend_q   <= 1'b0;
      frame_done_q <= 1'b0;
      fcs_ok_q     <= 1'b0;
      rx_error_q   <= 1'b0;
`ifdef MAC_RX_FCS_CHECK_EN
      crc_q        <= '1;
      match_q      <= 1'b0;
      end_pend2_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dv_prev_q    <= dv_prev_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      dst_q        <= dst_d;
      shadow_q     <= shadow_d;
      type_hi_q    <= type_hi_d;
      sel_arp_q    <= sel_arp_d;
      rx_data_q    <= rx_data_d;
      remote_q     <= remote_d;
      bcast_q      <= bcast_d;
      arp_en_q     <= arp_en_d;
      ip_en_q      <= ip_en_d;
      end_pend_q   <= end_pend_d;
      frame_done_q <= frame_done_d;
      fcs_ok_q     <= fcs_ok_d;
      rx_error_q   <= rx_error_d;
`ifdef MAC_RX_FCS_CHECK_EN
      crc_q        <= crc_d;
      match_q      <= match_d;
      end_pend2_q  <= end_pend2_d;
`endif
    end
  end

  assign rx_data_o       = rx_data_q;
  assign remote_mac_o    = remote_q;
  assign arp_rx_enable_o = arp_en_q;
  assign ip_rx_enable_o  = ip_en_q;
  assign is_broadcast_o  = bcast_q;
  assign frame_done_o    = frame_done_q;
  assign fcs_ok_o        = fcs_ok_q;
  assign rx_error_o      = rx_error_q;

endmodule

// File: tb/tb_mac_rx_dispatch.sv
// tb_mac_rx_dispatch: directed and randomized frames for mac_rx_dispatch.
// The reference model decides from frame fields (preamble, addresses,
// ethertype, truncation, reset point, length) what each cycle must show.
// Those per-cycle expectations are stored in arrays indexed by clock edge.
// A negedge monitor compares every cycle against them.

module tb_mac_rx_dispatch;

  localparam int MAXC = 20000;
  localparam int MAX_FRAME = 1522;
  localparam int PREAMBLE_MIN = 2;
  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
`ifdef MAC_RX_FCS_CHECK_EN
  localparam int DONE_LAT = 2;
  localparam bit FCS_CHECKED = 1'b1;
`else
  localparam int DONE_LAT = 1;
  localparam bit FCS_CHECKED = 1'b0;
`endif

  logic        rx_clock = 1'b0;
  logic        reset;
  logic        phy_rx_dv;
  logic [7:0]  phy_rx_data;
  logic [47:0] local_mac;
  logic [7:0]  rx_data;
  logic [47:0] remote_mac;
  logic        arp_rx_enable, ip_rx_enable, is_broadcast, frame_done, fcs_ok, rx_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checkEn = 1'b0;

  bit          expArp [MAXC];
  bit          expIp [MAXC];
  bit          expDone [MAXC];
  bit          expFcs [MAXC];
  bit          expErr [MAXC];
  bit          expBcast [MAXC];
  bit          expRemChk [MAXC];
  logic [7:0]  expData [MAXC];
  logic [47:0] expRemote [MAXC];
  logic [47:0] modelRemote = '0;

  typedef struct {
    int          preLen;
    bit          preBad;
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    int          payLen;
    int          padLen;
    bit          corrupt;
    int          truncAt;
    int          resetAt;
    int          tailLen;
    int          gap;
  } frame_t;

  mac_rx_dispatch dut (
    .rx_clock        (rx_clock),
    .reset           (reset),
    .phy_rx_dv_i     (phy_rx_dv),
    .phy_rx_data_i   (phy_rx_data),
    .local_mac_i     (local_mac),
    .rx_data_o       (rx_data),
    .remote_mac_o    (remote_mac),
    .arp_rx_enable_o (arp_rx_enable),
    .ip_rx_enable_o  (ip_rx_enable),
    .is_broadcast_o  (is_broadcast),
    .frame_done_o    (frame_done),
    .fcs_ok_o        (fcs_ok),
    .rx_error_o      (rx_error)
  );

  always #5 rx_clock = ~rx_clock;

  // Edge counter: after posedge number e the monitor sees cyc == e
  always @(posedge rx_clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  function automatic frame_t defaultFrame();
    frame_t f;
    f.preLen = 7; f.preBad = 1'b0; f.dst = LOCAL_MAC; f.src = 48'h00_11_22_33_44_55;
    f.etype = 16'h0800; f.payLen = 46; f.padLen = 0; f.corrupt = 1'b0;
    f.truncAt = -1; f.resetAt = -1; f.tailLen = 0; f.gap = 4;
    return f;
  endfunction

  // Per-cycle monitor against the expectation arrays
  always @(negedge rx_clock) begin
    if (checkEn && cyc < MAXC) begin
      checkOutput("ctl_arp_ip_done_err", {arp_rx_enable, ip_rx_enable, frame_done, rx_error},
                  {expArp[cyc], expIp[cyc], expDone[cyc], expErr[cyc]});
      if (expArp[cyc] || expIp[cyc]) begin
        checkOutput("rx_data", rx_data, expData[cyc]);
        checkOutput("is_broadcast", is_broadcast, expBcast[cyc]);
      end
      if (expRemChk[cyc]) checkOutput("remote_mac", remote_mac, expRemote[cyc]);
      if (expDone[cyc]) checkOutput("fcs_ok", fcs_ok, expFcs[cyc]);
    end
  end

  // Build one frame, record what the receiver must show, then drive it
  task automatic applyStimulus(input frame_t f);
    logic [7:0]  q[$];
    logic [31:0] crc;
    int hdr, n, s, e, k;
    bit accept, overrun, isArp;
    for (int i = 0; i < f.preLen; i++) q.push_back(8'h55);
    if (f.preBad) q[0] = 8'h5A;
    q.push_back(8'hD5);
    hdr = q.size();
    for (int i = 5; i >= 0; i--) q.push_back(f.dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(f.src[i*8 +: 8]);
    q.push_back(f.etype[15:8]);
    q.push_back(f.etype[7:0]);
    for (int i = 0; i < f.payLen; i++) q.push_back((i >= f.payLen - f.padLen) ? 8'h00 : 8'($urandom));
    crc = 32'hFFFF_FFFF;
    for (int i = hdr; i < q.size(); i++) crc = crcByte(crc, q[i]);
    crc = ~crc;
    for (int b = 0; b < 4; b++) q.push_back(crc[b*8 +: 8]);
    if (f.corrupt) q[hdr+14] = q[hdr+14] ^ 8'(1 << $urandom_range(0, 7));
    if (f.truncAt >= 0) while (q.size() > hdr + f.truncAt) void'(q.pop_back());
    n = q.size();

    @(negedge rx_clock);
    s = cyc + 1;
    isArp = (f.etype == 16'h0806);
    accept = !f.preBad && (f.preLen >= PREAMBLE_MIN) && ((f.dst == LOCAL_MAC) || (f.dst == BCAST)) &&
             ((f.etype == 16'h0806) || (f.etype == 16'h0800)) && (n >= hdr + 14) &&
             ((f.resetAt < 0) || (f.resetAt > hdr + 13));
    overrun = 1'b0;
    if (accept) begin
      modelRemote = f.src;
      e = s + hdr + 13;
      expRemChk[e] = 1'b1;
      expRemote[e] = f.src;
      for (int i = hdr + 14; i < n; i++) begin
        if ((f.resetAt >= 0) && (i >= f.resetAt)) break;
        k = i - hdr + 1;
        e = s + i;
        if (k > MAX_FRAME) begin
          expErr[e] = 1'b1;
          overrun = 1'b1;
          break;
        end
        expArp[e] = isArp;
        expIp[e] = !isArp;
        expData[e] = q[i];
        expBcast[e] = (f.dst == BCAST);
        expRemChk[e] = 1'b1;
        expRemote[e] = f.src;
      end
      if (!overrun && (f.resetAt < 0) && (n > hdr + 14)) begin
        e = s + n + DONE_LAT;
        expDone[e] = 1'b1;
        expFcs[e] = FCS_CHECKED ? !f.corrupt : 1'b1;
      end
    end
    if (f.resetAt >= 0) modelRemote = '0;

    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge rx_clock);
      reset = (i == f.resetAt);
      phy_rx_dv = 1'b1;
      phy_rx_data = q[i];
    end
    @(negedge rx_clock);
    reset = 1'b0;
    phy_rx_dv = 1'b0;
    phy_rx_data = 8'($urandom);
    if (f.tailLen > 0) begin
      for (int i = 0; i < f.tailLen; i++) begin
        @(negedge rx_clock);
        phy_rx_dv = 1'b1;
        phy_rx_data = (i == 0) ? 8'h00 : 8'($urandom);
      end
      @(negedge rx_clock);
      phy_rx_dv = 1'b0;
    end
    repeat (f.gap) @(negedge rx_clock);
    checkOutput("remote_mac_end", remote_mac, modelRemote);
  endtask

  // Watchdog so the run always ends
  initial begin
    repeat (90000) @(posedge rx_clock);
    $display("[TB] FAIL watchdog: cycle budget exceeded, observed=%0d expected<%0d", cyc, 90000);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    frame_t f;
    int sel;
    reset = 1'b1;
    phy_rx_dv = 1'b0;
    phy_rx_data = 8'h00;
    local_mac = LOCAL_MAC;
    repeat (3) @(negedge rx_clock);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_remote_mac", remote_mac, 0);
    checkOutput("reset_flags", {arp_rx_enable, ip_rx_enable, is_broadcast, frame_done, fcs_ok, rx_error}, 0);
    reset = 1'b0;
    checkEn = 1'b1;

    // Broadcast ARP: 28 data bytes plus 18 pad bytes
    f = defaultFrame();
    f.dst = BCAST; f.etype = 16'h0806; f.payLen = 46; f.padLen = 18;
    applyStimulus(f);

    // Unicast IP to the local MAC
    f = defaultFrame();
    f.src = 48'hA0_B1_C2_D3_E4_F5; f.payLen = 30;
    applyStimulus(f);

    // Foreign destination, then unknown ethertype: both ignored
    f = defaultFrame();
    f.dst = OTHER_MAC; f.src = 48'h11_11_11_11_11_11;
    applyStimulus(f);
    f = defaultFrame();
    f.etype = 16'h86DD; f.src = 48'h22_22_22_22_22_22;
    applyStimulus(f);

    // Reset mid-payload, then a clean frame to show recovery
    f = defaultFrame();
    f.resetAt = 8 + 14 + 10;
    applyStimulus(f);
    f = defaultFrame();
    f.etype = 16'h0806; f.payLen = 20;
    applyStimulus(f);

    // 1600-byte frame overruns the limit
    f = defaultFrame();
    f.payLen = 1582;
    applyStimulus(f);

    // Corrupted payload bit, short preambles at and below the minimum
    f = defaultFrame();
    f.corrupt = 1'b1; f.payLen = 40;
    applyStimulus(f);
    f = defaultFrame();
    f.preLen = 1;
    applyStimulus(f);
    f = defaultFrame();
    f.preLen = 2; f.payLen = 10;
    applyStimulus(f);

    // Runt ending inside the header, and a one-cycle dv gap ending a frame
    f = defaultFrame();
    f.truncAt = 9; f.src = 48'h33_33_33_33_33_33;
    applyStimulus(f);
    f = defaultFrame();
    f.payLen = 12; f.tailLen = 5;
    applyStimulus(f);

    for (int t = 0; t < 40; t++) begin
      f = defaultFrame();
      f.preLen = $urandom_range(1, 7);
      f.preBad = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 5);
      f.dst = (sel < 3) ? LOCAL_MAC : (sel < 5) ? BCAST : {8'h04, 40'($urandom)};
      f.src = {16'($urandom), 32'($urandom)};
      sel = $urandom_range(0, 6);
      f.etype = (sel < 3) ? 16'h0800 : (sel < 6) ? 16'h0806 : 16'h86DD;
      f.payLen = $urandom_range(1, 60);
      f.corrupt = ($urandom_range(0, 3) == 0);
      f.truncAt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 13) : -1;
      f.tailLen = ($urandom_range(0, 5) == 0) ? $urandom_range(3, 6) : 0;
      f.gap = $urandom_range(3, 5);
      applyStimulus(f);
    end

    repeat (6) @(negedge rx_clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
